// File: rtl/lcd_timing_pkg.sv
// Shared raster timing defaults (640x480@60), scan-out FSM states and
// total-length helpers for the LCD read side.
package lcd_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    function automatic int h_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/lcd_scanout_if.sv
// FIFO read port as seen from the scan-out block (master) and the FIFO (slave).
interface lcd_scanout_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_empty;
    logic                  almost_empty;

    modport master (output rd_en, input rd_data, input rd_empty, input almost_empty);
    modport slave  (input rd_en, output rd_data, output rd_empty, output almost_empty);
endinterface

// File: rtl/lcd_timing_gen.sv
// Horizontal/vertical raster counters with region decode. Counters only move
// while run is high and sit at the origin otherwise.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic active,
    output logic hsync,
    output logic vsync,
    output logic frame_end,
    output logic frame_origin
);

    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          line_end;

    assign line_end     = (h_cnt == H_LAST);
    assign frame_end    = line_end && (v_cnt == V_LAST);
    assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
    assign active       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync        = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vsync        = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/lcd_scanout.sv
// LCD scan-out: pops one FIFO pixel per active clock and drives RGB strobes and
// data through a two-stage pipeline so data and sync stay aligned at the pins.
module lcd_scanout
    import lcd_timing_pkg::*;
#(
    parameter int                    H_ACTIVE        = DEF_H_ACTIVE,
    parameter int                    H_FP            = DEF_H_FP,
    parameter int                    H_SYNC          = DEF_H_SYNC,
    parameter int                    H_BP            = DEF_H_BP,
    parameter int                    V_ACTIVE        = DEF_V_ACTIVE,
    parameter int                    V_FP            = DEF_V_FP,
    parameter int                    V_SYNC          = DEF_V_SYNC,
    parameter int                    V_BP            = DEF_V_BP,
    parameter logic                  HS_POL          = 1'b0,
    parameter logic                  VS_POL          = 1'b0,
    parameter int                    DATA_WIDTH      = 16,
    parameter logic [DATA_WIDTH-1:0] UNDERFLOW_COLOR = 16'hF800
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  lcd_en,
    input  logic                  underflow_clr,
    lcd_scanout_if.master         fifo,
    output logic                  lcd_hs,
    output logic                  lcd_vs,
    output logic                  lcd_de,
    output logic [DATA_WIDTH-1:0] lcd_data,
    output logic                  frame_start,
    output logic                  underflow,
    output logic                  busy
);

    state_t state, state_nxt;
    logic   run, fetch, miss;
    logic   active, hsync, vsync, frame_end, frame_origin;
    logic   s1_de, s1_hs, s1_vs, s1_miss;

    lcd_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk          (rd_clk),
        .rst          (rd_rst),
        .run          (run),
        .active       (active),
        .hsync        (hsync),
        .vsync        (vsync),
        .frame_end    (frame_end),
        .frame_origin (frame_origin)
    );

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (lcd_en) state_nxt = PRIME;
            PRIME:   if (!lcd_en) state_nxt = IDLE;
                     else if (!fifo.almost_empty) state_nxt = RUN;
            RUN:     if (frame_end && !lcd_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign run         = (state == RUN);
    assign busy        = (state != IDLE);
    assign fetch       = run && active;
    assign fifo.rd_en  = fetch && !fifo.rd_empty;
    assign miss        = fetch && fifo.rd_empty;
    assign frame_start = run && frame_origin;

    // Stage 1 holds the decode for the pixel whose FIFO word arrives this cycle.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            s1_de    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_miss  <= 1'b0;
            lcd_de   <= 1'b0;
            lcd_hs   <= ~HS_POL;
            lcd_vs   <= ~VS_POL;
            lcd_data <= '0;
        end else begin
            s1_de    <= fetch;
            s1_hs    <= run && hsync;
            s1_vs    <= run && vsync;
            s1_miss  <= miss;
            lcd_de   <= s1_de;
            lcd_hs   <= s1_hs ? HS_POL : ~HS_POL;
            lcd_vs   <= s1_vs ? VS_POL : ~VS_POL;
            lcd_data <= !s1_de ? '0 : (s1_miss ? UNDERFLOW_COLOR : fifo.rd_data);
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst)             underflow <= 1'b0;
        else if (miss)          underflow <= 1'b1;
        else if (underflow_clr) underflow <= 1'b0;
    end

endmodule

// File: tb/tb_lcd_scanout.sv
// Self-checking bench for lcd_scanout on a 4x2 raster: a reference model predicts
// each stage-0 pixel, queues it and compares it two clocks later at the pins.
module tb_lcd_scanout;
    import lcd_timing_pkg::*;

    localparam int HA = 4, HFP = 1, HSY = 1, HBP = 1;
    localparam int VA = 2, VFP = 1, VSY = 1, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam logic [15:0] UF_COLOR = 16'hF800;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [15:0] data;
    } pins_t;

    localparam pins_t BLANK = '{de: 1'b0, hs: 1'b1, vs: 1'b1, data: 16'h0000};

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b0;
    logic        lcd_en = 1'b0;
    logic        underflow_clr = 1'b0;
    logic        lcd_hs, lcd_vs, lcd_de, frame_start, underflow, busy;
    logic [15:0] lcd_data;

    int checks = 0;
    int errors = 0;
    int f_rd_idx = 0;

    state_t m_state;
    int     m_pos, m_rd;
    logic   m_uf;
    pins_t  sb[$];

    lcd_scanout_if #(.DATA_WIDTH(16)) fifo ();

    lcd_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .DATA_WIDTH(16), .UNDERFLOW_COLOR(UF_COLOR)
    ) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .lcd_en        (lcd_en),
        .underflow_clr (underflow_clr),
        .fifo          (fifo),
        .lcd_hs        (lcd_hs),
        .lcd_vs        (lcd_vs),
        .lcd_de        (lcd_de),
        .lcd_data      (lcd_data),
        .frame_start   (frame_start),
        .underflow     (underflow),
        .busy          (busy)
    );

    always #5 rd_clk = ~rd_clk;

    function automatic logic [15:0] pix(int i);
        return 16'(i * 40503 + 4660);
    endfunction

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // FIFO: word popped by rd_en appears on rd_data the following cycle.
    always @(posedge rd_clk) begin
        if (fifo.rd_en) begin
            fifo.rd_data <= pix(f_rd_idx);
            f_rd_idx     <= f_rd_idx + 1;
        end
    end

    task automatic model_step();
        int    h, v;
        logic  run, act, hs_on, vs_on;
        pins_t e;
        if (rd_rst) begin
            m_state = IDLE;
            m_pos   = 0;
            m_uf    = 1'b0;
            sb      = '{BLANK, BLANK};
        end
        run   = (m_state == RUN);
        h     = m_pos % HT;
        v     = m_pos / HT;
        act   = run && (h < HA) && (v < VA);
        hs_on = run && (h >= HA + HFP) && (h < HA + HFP + HSY);
        vs_on = run && (v >= VA + VFP) && (v < VA + VFP + VSY);
        check("rd_en", fifo.rd_en, act && !fifo.rd_empty);
        check("frame_start", frame_start, run && (m_pos == 0));
        check("busy", busy, m_state != IDLE);
        check("underflow", underflow, m_uf);
        e.de   = act;
        e.hs   = !hs_on;
        e.vs   = !vs_on;
        e.data = !act ? 16'h0000 : (fifo.rd_empty ? UF_COLOR : pix(m_rd));
        sb.push_back(e);
        e = sb.pop_front();
        check("de_hs_vs", {lcd_de, lcd_hs, lcd_vs}, {e.de, e.hs, e.vs});
        check("lcd_data", lcd_data, e.data);
        if (rd_rst) return;
        if (act && !fifo.rd_empty) m_rd++;
        if (act && fifo.rd_empty) m_uf = 1'b1;
        else if (underflow_clr)   m_uf = 1'b0;
        case (m_state)
            IDLE:  if (lcd_en) m_state = PRIME;
            PRIME: if (!lcd_en) m_state = IDLE;
                   else if (!fifo.almost_empty) m_state = RUN;
            default: begin
                if (m_pos == FRAME - 1) begin
                    m_pos = 0;
                    if (!lcd_en) m_state = IDLE;
                end else begin
                    m_pos++;
                end
            end
        endcase
    endtask

    initial begin
        m_state = IDLE;
        m_pos   = 0;
        m_rd    = 0;
        m_uf    = 1'b0;
        sb      = '{BLANK, BLANK};
        forever begin
            @(negedge rd_clk);
            model_step();
        end
    end

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge rd_clk);
            #1;
        end
    endtask

    task automatic wait_frame_start();
        int k = 0;
        do begin
            @(negedge rd_clk);
            k++;
        end while (frame_start !== 1'b1 && k < 200);
        check("frame_start_seen", frame_start, 1);
    endtask

    initial begin
        int seen, base, de_n, hs_n, vs_n;
        fifo.rd_empty     = 1'b0;
        fifo.almost_empty = 1'b1;
        #2 rd_rst = 1'b1;
        cycle(3);
        rd_rst = 1'b0;
        cycle(3);
        check("idle_busy", busy, 0);

        // Prime gating: FIFO reports almost empty for 100 clocks.
        lcd_en = 1'b1;
        seen = 0;
        repeat (100) begin
            @(negedge rd_clk);
            seen |= int'(fifo.rd_en | frame_start);
        end
        check("prime_quiet", seen, 0);
        check("prime_busy", busy, 1);
        cycle();
        fifo.almost_empty = 1'b0;
        @(negedge rd_clk);
        check("fs_before_run", frame_start, 0);
        @(negedge rd_clk);
        check("fs_after_prime", frame_start, 1);

        // Full frame counts.
        base = f_rd_idx;
        de_n = 0; hs_n = 0; vs_n = 0;
        repeat (FRAME) begin
            @(negedge rd_clk);
            de_n += int'(lcd_de);
            hs_n += int'(!lcd_hs);
            vs_n += int'(!lcd_vs);
        end
        check("reads_per_frame", f_rd_idx - base, HA * VA);
        check("de_per_frame", de_n, HA * VA);
        check("hs_low_per_frame", hs_n, HSY * VT);
        check("vs_low_per_frame", vs_n, VSY * HT);
        check("fs_second_frame", frame_start, 1);

        // Underflow on pixels 1..3 of line 0.
        cycle();
        fifo.rd_empty = 1'b1;
        cycle(3);
        fifo.rd_empty = 1'b0;
        check("underflow_set", underflow, 1);
        @(negedge rd_clk);
        check("underflow_color", lcd_data, UF_COLOR);

        // Clear coinciding with a new underflow: set wins; then a plain clear.
        wait_frame_start();
        cycle();
        fifo.rd_empty = 1'b1;
        underflow_clr = 1'b1;
        cycle();
        fifo.rd_empty = 1'b0;
        underflow_clr = 1'b0;
        check("uf_set_wins", underflow, 1);
        cycle();
        underflow_clr = 1'b1;
        cycle();
        underflow_clr = 1'b0;
        check("uf_cleared", underflow, 0);

        // Disable in line 1: the frame still completes, then IDLE with no reads.
        wait_frame_start();
        cycle(7);
        lcd_en = 1'b0;
        base = f_rd_idx;
        cycle(FRAME - 8);
        check("busy_last_pixel", busy, 1);
        check("reads_after_disable", f_rd_idx - base, HA);
        cycle();
        check("idle_after_frame", busy, 0);
        base = f_rd_idx;
        cycle(20);
        check("no_reads_idle", f_rd_idx - base, 0);

        // Async reset in the middle of an active pixel.
        lcd_en = 1'b1;
        wait_frame_start();
        cycle(9);
        rd_rst = 1'b1;
        #1;
        check("reset_strobes", {lcd_de, lcd_hs, lcd_vs, fifo.rd_en, frame_start, busy, underflow},
              7'b0110000);
        check("reset_data", lcd_data, 0);
        cycle(2);
        rd_rst = 1'b0;
        check("busy_after_release", busy, 0);
        cycle();
        check("prime_after_release", busy, 1);
        wait_frame_start();
        cycle(FRAME + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_scanout.md
# lcd_scanout

Read-side consumer of the LCD pixel FIFO. It generates raster timing for a parallel RGB LCD, pops one 16-bit RGB565 pixel from the FIFO for every active pixel, and drives `lcd_hs`, `lcd_vs`, `lcd_de` and `lcd_data`. It sits entirely in the pixel-clock domain, between the FIFO read port and the LCD pins. It also reports underflow and provides a frame-start strobe so the write side can realign.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48: horizontal front porch, sync and back porch, in clocks.
- `V_ACTIVE`, 480: active lines per frame.
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33: vertical front porch, sync and back porch, in lines.
- `HS_POL` / `VS_POL`, 0 / 0: sync active level (0 = active-low).
- `DATA_WIDTH`, 16: pixel width; must equal the FIFO read width.
- `UNDERFLOW_COLOR`, 16'hF800: value driven on `lcd_data` for a pixel the FIFO cannot supply.
- `rd_clk`, in, 1: pixel clock. This is the block's single clock.
- `rd_rst`, in, 1: reset, asynchronous, active-high.
- `lcd_en`, in, 1: request to scan out.
- `underflow_clr`, in, 1: clears the sticky `underflow` flag.
- `rd_en`, out, 1: FIFO read enable.
- `rd_data`, in, DATA_WIDTH: FIFO read data, valid the cycle after `rd_en`.
- `rd_empty`, in, 1: FIFO empty.
- `almost_empty`, in, 1: FIFO almost empty.
- `lcd_hs`, out, 1: horizontal sync.
- `lcd_vs`, out, 1: vertical sync.
- `lcd_de`, out, 1: data enable.
- `lcd_data`, out, DATA_WIDTH: pixel data.
- `frame_start`, out, 1: one-clock pulse at the start of each frame.
- `underflow`, out, 1: sticky underflow flag.
- `busy`, out, 1: high whenever the block is not in IDLE.

## Operation
**Counters**
- `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
- `v_cnt` runs 0..V_TOTAL-1 and increments when `h_cnt` wraps.
- Both counters are cleared to 0 and held there outside RUN.
- Counter widths are `$clog2(H_TOTAL)` and `$clog2(V_TOTAL)`.

**Region decode (per line and per frame)**
- Active region comes first: `h_cnt < H_ACTIVE` and `v_cnt < V_ACTIVE`.
- Front porch follows, then sync, then back porch.
- hsync is asserted for `H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC`. vsync uses the same rule on `v_cnt`.

**State machine**
- IDLE: outputs at their reset levels. Go to PRIME when `lcd_en` = 1.
- PRIME: wait for `almost_empty` = 0. Go to RUN when it is seen. If `lcd_en` drops here, return to IDLE.
- RUN: counters advance every clock. The block leaves RUN only at the frame boundary (h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1). At that point it goes to IDLE if `lcd_en` = 0, otherwise it stays in RUN. A frame is never truncated.

**Pixel fetch**
- In RUN and in the active region: `rd_en = ~rd_empty` (combinational from `rd_empty` and the stage-0 decode).
- If `rd_empty` = 1 at an active pixel, no pop is issued. That pixel's `lcd_data` = UNDERFLOW_COLOR and `underflow` is set.
- The block never reads outside the active region and never reads while the FIFO is empty.

**Underflow flag**
- `underflow` is set by an underflow and cleared by `underflow_clr`.
- If both happen in the same cycle, set wins.

**Frame start**
- `frame_start` pulses for one clock when stage 0 is at (0,0) in RUN, including the first frame after PRIME.

## Timing
- Pipeline stage 0 is the counters plus `rd_en`.
- Stage 1 registers the decoded hs/vs/de and a `miss` bit.
- Stage 2 registers `lcd_hs`, `lcd_vs` and `lcd_de`, and sets `lcd_data = miss ? UNDERFLOW_COLOR : rd_data` (value captured in stage 1). Outside de, `lcd_data` = 0.
- Latency from counters to pins is 2 clocks for all outputs, so data and strobes stay aligned. `frame_start` is not delayed.
- Reset values: `rd_en` = 0, `lcd_de` = 0, `lcd_data` = 0, `lcd_hs` = ~HS_POL, `lcd_vs` = ~VS_POL, `frame_start` = 0, `underflow` = 0, `busy` = 0, state IDLE.
- Reset asserted mid-frame clears everything immediately. No partial line is emitted after release.
- On leaving RUN, the stage-1 and stage-2 contents drain normally over 2 clocks.

## Structure
- Package `lcd_timing_pkg`: default timing constants (640x480@60), a state enum {IDLE, PRIME, RUN}, and the H_TOTAL/V_TOTAL helper functions.
- Sub-module `lcd_timing_gen`: h/v counters, region decode and the frame-boundary flag.
- Top level `lcd_scanout`: FSM, fetch, pipeline and flags.

## Test plan
- **Full frame:** FIFO model preloaded and kept non-empty; `lcd_en` = 1. Require 480 lines of 640 `lcd_de` clocks, hs low for 96 clocks per 800, vs low for 2 lines per 525, and pixels in FIFO order with 2-clock alignment.
- **Prime gating:** `almost_empty` held at 1 for 100 clocks after `lcd_en`. Require no `rd_en` and no `frame_start` during that time, then `frame_start` 1 clock after `almost_empty` falls.
- **Underflow:** `rd_empty` = 1 for pixels 10..12 of line 0. Require `rd_en` = 0 on those 3 pixels, `lcd_data` = 16'hF800 on them, and `underflow` = 1. Pulse `underflow_clr` together with a new underflow: flag stays 1.
- **Disable mid-frame:** `lcd_en` dropped at line 200. Require the frame to complete to v = 524/h = 799, then IDLE with `busy` = 0 and no further reads.
- **Async reset:** `rd_rst` asserted at line 100, pixel 300. Require all outputs at reset values within the same cycle and restart via PRIME after release.
- **Small timing:** H_ACTIVE = 4, H_FP = H_SYNC = H_BP = 1, V_ACTIVE = 2, V_FP = V_SYNC = V_BP = 1. Check counter wrap at 6/4 and exactly 8 reads per frame.
